vm2002_purchase_seq: RTL and testbench
======================================

// Module: vm2002_purchase_seq
// PURPOSE
//  User-side initiator for the vm2002 user-mode handshake. Takes one purchase request (item + payment
//  in cents), drives buttons/coin/select/srst toward the vending machine and reports a result code.
//  Sits between a host/bench request port and the machine's user-mode interface.
//  Also serves as a synthesizable stimulus source.
// PARAMETERS
//  AMT_W        8     width of amount fields, cents
//  SRST_CYCLES  2     cycles srst held high on abort
//  WDOG_CYCLES  1024  max cycles spent in any wait state before watchdog abort
// PORTS
//  clk                  in   1      clock, rising edge
//  hrst_n               in   1      async active-low reset
//  req_valid            in   1      purchase request valid
//  req_ready            out  1      high only in IDLE; accept = req_valid & req_ready
//  req_item             in   3      item code 1..7; 0 rejected (result BADREQ)
//  req_amount           in   AMT_W  initial payment, cents
//  req_topup            in   AMT_W  extra payment used once on insufficient_amount; 0 = none
//  buttons              out  3      item select toward machine
//  coin                 out  2      00 none, 01 5c, 10 10c, 11 25c; one coin per cycle
//  select               out  1      purchase confirm
//  srst                 out  1      soft reset / transaction abort
//  status               in   2      00 BUSY, 01 AVAILABLE, 10 OUT_OF_STOCK, 11 ERROR
//  insert_coins         in   1      machine ready for coins
//  start_timer          in   1      machine selection timer running
//  timeout              in   1      machine selection timeout
//  insufficient_amount  in   1      machine reports underpayment
//  done                 out  1      one-cycle pulse, result valid
//  result               out  3      0 OK, 1 OUT_OF_STOCK, 2 ERROR, 3 TIMEOUT, 4 INSUFF, 5 WDOG, 6 BADREQ
// BEHAVIOUR
//  Reset: state IDLE; buttons/coin/select/srst/done = 0, result = 0, req_ready = 1. Mid-op reset: abandon, no done.
//  All outputs registered; inputs sampled on rising clk.
//  Amounts rounded down to a multiple of 5 (low remainder dropped); captured at accept with item.
//  FSM:
//   IDLE:     on accept, item==0 -> DONE(BADREQ); else buttons<=item next cycle -> PRESS.
//   PRESS:    hold buttons; status AVAILABLE -> WAIT_INS; OUT_OF_STOCK -> DONE(1); ERROR -> ABORT(2).
//   WAIT_INS: wait insert_coins & start_timer both 1 -> PAY (rem<=amount).
//   PAY:      greedy one coin/cycle: rem>=25 ->11, else >=10 ->10, else >=5 ->01; rem -= value;
//             rem<5 -> coin=00, SELECT. Amount 0 -> first PAY cycle goes straight to SELECT.
//   SELECT:   select=1 held; wait start_timer==0, then sample insufficient_amount next cycle:
//             0 -> DONE(OK); 1 & topup unused & topup!=0 -> rem<=topup, mark used, PAY (select held);
//             1 otherwise -> DONE(INSUFF).
//   ABORT:    srst=1 for SRST_CYCLES, all other outputs 0, then DONE.
//   DONE:     done=1 one cycle with result; buttons/coin/select/srst=0 same cycle; IDLE next cycle.
//  Priority each cycle in WAIT_INS/PAY/SELECT: status==ERROR -> ABORT(2) > timeout==1 -> DONE(3), no srst
//   > watchdog > normal transition. timeout and start_timer falling together -> TIMEOUT.
//  Watchdog: counter cleared on state change; reaching WDOG_CYCLES in PRESS/WAIT_INS/SELECT -> ABORT(5).
//  Latency: accept at edge N -> buttons valid after N+1; req_valid ignored outside IDLE.
//  rem never underflows (compare before subtract); max coins per payment = ceil(2^AMT_W/25)+2.
// TESTING
//  1 item 3, amount 40, AVAILABLE, start_timer falls, insuff=0 -> coins 11,10,01; select; done, result 0.
//  2 item 5, status OUT_OF_STOCK -> no coin, no select; done result 1, buttons 0 on done.
//  3 amount 10, topup 25, insuff=1 after timer -> coin 10, then 11; second insuff=0 -> result 0;
//    repeat with insuff=1 again -> result 4.
//  4 timeout=1 during PAY of amount 75 -> coins stop, done result 3, srst never asserted.
//  5 status ERROR in WAIT_INS -> srst high exactly 2 cycles, then done result 2; insert_coins never 1 with
//    WDOG_CYCLES=16 -> done result 5 after 16 cycles + abort.
//  6 hrst_n low during PAY -> outputs 0 asynchronously, req_ready=1, no done; item 0 -> done result 6.

Source files
------------

// File: rtl/vm2002_purchase_seq.sv
// vm2002_purchase_seq: user-side initiator for one vm2002 purchase.
// Accepts one request (item and payment in cents), presses the item button,
// pays greedily one coin per cycle, confirms with select, and reports a result.
// Ports:
//   clk, hrst_n                   clock, async active-low reset
//   req_valid/req_ready           request handshake (ready only while idle)
//   req_item/req_amount/req_topup request payload
//   buttons/coin/select/srst      drive toward the machine (registered)
//   status/insert_coins/start_timer/timeout/insufficient_amount  machine feedback
//   done/result                   one-cycle completion pulse and result code
module vm2002_purchase_seq #(
    parameter int unsigned AMT_W       = 8,
    parameter int unsigned SRST_CYCLES = 2,
    parameter int unsigned WDOG_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             hrst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_item,
    input  logic [AMT_W-1:0] req_amount,
    input  logic [AMT_W-1:0] req_topup,
    output logic [2:0]       buttons,
    output logic [1:0]       coin,
    output logic             select,
    output logic             srst,
    input  logic [1:0]       status,
    input  logic             insert_coins,
    input  logic             start_timer,
    input  logic             timeout,
    input  logic             insufficient_amount,
    output logic             done,
    output logic [2:0]       result
);

    localparam int unsigned WD_W = $clog2(WDOG_CYCLES + 1);
    localparam int unsigned SR_W = (SRST_CYCLES > 1) ? $clog2(SRST_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);
    localparam logic [SR_W-1:0] SR_LAST = SR_W'(SRST_CYCLES - 1);

    localparam logic [1:0] ST_AVAIL = 2'b01;
    localparam logic [1:0] ST_OOS   = 2'b10;
    localparam logic [1:0] ST_ERR   = 2'b11;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;
    localparam logic [1:0] COIN_25   = 2'b11;

    localparam logic [2:0] RES_OK     = 3'd0;
    localparam logic [2:0] RES_OOS    = 3'd1;
    localparam logic [2:0] RES_ERR    = 3'd2;
    localparam logic [2:0] RES_TMO    = 3'd3;
    localparam logic [2:0] RES_INSUFF = 3'd4;
    localparam logic [2:0] RES_WDOG   = 3'd5;
    localparam logic [2:0] RES_BADREQ = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE, S_PRESS, S_WAIT_INS, S_PAY, S_SELECT, S_SEL_CHK, S_ABORT, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [AMT_W-1:0]  rem_q, rem_d, topup_q, topup_d;
    logic              used_q, used_d;
    logic [2:0]        item_q, item_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic [SR_W-1:0]   srst_cnt_q, srst_cnt_d;
    logic              req_ready_q, req_ready_d, select_q, select_d;
    logic              srst_q, srst_d, done_q, done_d;
    logic [2:0]        buttons_q, buttons_d, result_q, result_d;
    logic [1:0]        coin_q, coin_d;
    logic              wdog_hit;

    // Drop the sub-nickel remainder; the machine only takes 5c multiples.
    function automatic logic [AMT_W-1:0] round5(input logic [AMT_W-1:0] a);
        return a - (a % AMT_W'(5));
    endfunction

    assign wdog_hit = (wdog_q == WD_LAST);

    // Next-state, payload and registered-output decode.
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        topup_d    = topup_q;
        used_d     = used_q;
        item_d     = item_q;
        result_d   = result_q;
        srst_cnt_d = '0;
        coin_d     = COIN_NONE;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    item_d  = req_item;
                    rem_d   = round5(req_amount);
                    topup_d = round5(req_topup);
                    used_d  = 1'b0;
                    if (req_item == 3'd0) begin
                        state_d  = S_DONE;
                        result_d = RES_BADREQ;
                    end else begin
                        state_d = S_PRESS;
                    end
                end
            end
            S_PRESS: begin
                if (status == ST_AVAIL) begin
                    state_d = S_WAIT_INS;
                end else if (status == ST_OOS) begin
                    state_d  = S_DONE;
                    result_d = RES_OOS;
                end else if (status == ST_ERR) begin
                    state_d  = S_ABORT;
                    result_d = RES_ERR;
                end else if (wdog_hit) begin
                    state_d  = S_ABORT;
                    result_d = RES_WDOG;
                end
            end
            S_WAIT_INS, S_PAY, S_SELECT, S_SEL_CHK: begin
                // Machine error beats timeout, which beats the watchdog.
                if (status == ST_ERR) begin
                    state_d  = S_ABORT;
                    result_d = RES_ERR;
                end else if (timeout) begin
                    state_d  = S_DONE;
                    result_d = RES_TMO;
                end else if (wdog_hit && (state_q != S_PAY)) begin
                    state_d  = S_ABORT;
                    result_d = RES_WDOG;
                end else begin
                    case (state_q)
                        S_WAIT_INS: begin
                            if (insert_coins && start_timer) state_d = S_PAY;
                        end
                        S_PAY: begin
                            if (rem_q >= AMT_W'(25)) begin
                                coin_d = COIN_25;
                                rem_d  = rem_q - AMT_W'(25);
                            end else if (rem_q >= AMT_W'(10)) begin
                                coin_d = COIN_10;
                                rem_d  = rem_q - AMT_W'(10);
                            end else if (rem_q >= AMT_W'(5)) begin
                                coin_d = COIN_5;
                                rem_d  = rem_q - AMT_W'(5);
                            end else begin
                                state_d = S_SELECT;
                            end
                        end
                        S_SELECT: begin
                            if (!start_timer) state_d = S_SEL_CHK;
                        end
                        default: begin
                            if (!insufficient_amount) begin
                                state_d  = S_DONE;
                                result_d = RES_OK;
                            end else if (!used_q && (topup_q != '0)) begin
                                state_d = S_PAY;
                                rem_d   = topup_q;
                                used_d  = 1'b1;
                            end else begin
                                state_d  = S_DONE;
                                result_d = RES_INSUFF;
                            end
                        end
                    endcase
                end
            end
            S_ABORT: begin
                if (srst_cnt_q == SR_LAST) state_d = S_DONE;
                else                       srst_cnt_d = srst_cnt_q + SR_W'(1);
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Watchdog counts cycles spent in the current state.
        if (state_d != state_q)  wdog_d = '0;
        else if (wdog_hit)       wdog_d = wdog_q;
        else                     wdog_d = wdog_q + WD_W'(1);

        req_ready_d = (state_d == S_IDLE);
        done_d      = (state_d == S_DONE);
        srst_d      = (state_d == S_ABORT);
        buttons_d   = (state_d inside {S_PRESS, S_WAIT_INS, S_PAY, S_SELECT, S_SEL_CHK})
                      ? item_d : 3'd0;
        // Select stays up while paying the top-up after a first confirm.
        select_d    = (state_d inside {S_SELECT, S_SEL_CHK}) || ((state_d == S_PAY) && used_d);
    end

    // State, payload and output registers.
    always_ff @(posedge clk or negedge hrst_n) begin
        if (!hrst_n) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            topup_q     <= '0;
            used_q      <= 1'b0;
            item_q      <= '0;
            wdog_q      <= '0;
            srst_cnt_q  <= '0;
            req_ready_q <= 1'b1;
            buttons_q   <= '0;
            coin_q      <= COIN_NONE;
            select_q    <= 1'b0;
            srst_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= RES_OK;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            topup_q     <= topup_d;
            used_q      <= used_d;
            item_q      <= item_d;
            wdog_q      <= wdog_d;
            srst_cnt_q  <= srst_cnt_d;
            req_ready_q <= req_ready_d;
            buttons_q   <= buttons_d;
            coin_q      <= coin_d;
            select_q    <= select_d;
            srst_q      <= srst_d;
            done_q      <= done_d;
            result_q    <= result_d;
        end
    end

    assign req_ready = req_ready_q;
    assign buttons   = buttons_q;
    assign coin      = coin_q;
    assign select    = select_q;
    assign srst      = srst_q;
    assign done      = done_q;
    assign result    = result_q;

endmodule

// File: tb/tb_vm2002_purchase_seq.sv
// Bench for vm2002_purchase_seq: a cycle-level vending-machine responder plus
// a reference model deriving coin sequence, result, srst length and select
// activity from the purchase parameters by plain arithmetic.
module tb_vm2002_purchase_seq;

    localparam int unsigned AMT_W = 8;

    logic             clk = 1'b0;
    logic             hrst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [2:0]       req_item = '0;
    logic [AMT_W-1:0] req_amount = '0;
    logic [AMT_W-1:0] req_topup = '0;
    logic [2:0]       buttons;
    logic [1:0]       coin;
    logic             select;
    logic             srst;
    logic [1:0]       status = 2'b00;
    logic             insert_coins = 1'b0;
    logic             start_timer = 1'b0;
    logic             timeout = 1'b0;
    logic             insufficient_amount = 1'b0;
    logic             done;
    logic [2:0]       result;

    vm2002_purchase_seq #(.AMT_W(AMT_W), .SRST_CYCLES(2), .WDOG_CYCLES(16)) dut (
        .clk(clk), .hrst_n(hrst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_item(req_item), .req_amount(req_amount), .req_topup(req_topup),
        .buttons(buttons), .coin(coin), .select(select), .srst(srst),
        .status(status), .insert_coins(insert_coins), .start_timer(start_timer),
        .timeout(timeout), .insufficient_amount(insufficient_amount),
        .done(done), .result(result)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Monitor record for the current transaction
    logic [1:0] obs_coins[$];
    logic [1:0] exp_coins[$];
    int         coins_seen, srst_cyc, done_cnt;
    logic       sel_seen;
    logic [2:0] done_res;
    logic [6:0] done_bus;

    // Machine responder configuration and state
    logic [1:0] m_status;
    bit         m_ins, m_err_wait, m_r0, m_r1;
    int         m_to_after;
    int         wait_cnt, sel_cnt;
    bit         timer_dropped;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic clear_mon();
        obs_coins.delete();
        coins_seen = 0; srst_cyc = 0; done_cnt = 0; sel_seen = 1'b0;
        done_res = '0; done_bus = '0;
    endtask

    // One clock: sample DUT outputs after the edge, then respond as the machine would.
    task automatic step();
        @(posedge clk); #1;
        if (coin != 2'b00) begin obs_coins.push_back(coin); coins_seen++; end
        if (srst) srst_cyc++;
        if (select) sel_seen = 1'b1;
        if (done) begin
            done_cnt++;
            done_res = result;
            done_bus = {buttons, coin, select, srst};
        end
        if (buttons == 3'd0) begin
            status = 2'b00; insert_coins = 1'b0; start_timer = 1'b0;
            timeout = 1'b0; insufficient_amount = 1'b0;
            wait_cnt = 0; sel_cnt = 0; timer_dropped = 1'b0;
        end else begin
            status = m_status;
            if (m_status == 2'b01) begin
                if (m_err_wait && wait_cnt >= 2) status = 2'b11;
                wait_cnt++;
                if (m_ins && !timer_dropped) begin insert_coins = 1'b1; start_timer = 1'b1; end
            end
            if (select && !timer_dropped) begin
                sel_cnt++;
                if (sel_cnt >= 2) begin
                    start_timer = 1'b0; insert_coins = 1'b0; timer_dropped = 1'b1;
                    insufficient_amount = m_r0;
                end
            end
            if (coin != 2'b00 && timer_dropped) insufficient_amount = m_r1;
            if (m_to_after > 0 && coins_seen >= m_to_after) timeout = 1'b1;
        end
    endtask

    // Greedy change for a payment after rounding down to 5c.
    function automatic void add_coins(input int a);
        int r, q, d, n;
        r = a - (a % 5);
        q = r / 25; d = (r % 25) / 10; n = ((r % 25) % 10) / 5;
        repeat (q) exp_coins.push_back(2'b11);
        repeat (d) exp_coins.push_back(2'b10);
        repeat (n) exp_coins.push_back(2'b01);
    endfunction

    task automatic do_txn(input string tag, input logic [2:0] item, input int amount, input int topup,
                          input logic [1:0] st, input bit ins, input bit errw,
                          input int to_after, input bit r0, input bit r1);
        logic [2:0] exp_res;
        int         topup5, cyc;
        m_status = st; m_ins = ins; m_err_wait = errw; m_to_after = to_after;
        m_r0 = r0; m_r1 = r1;
        clear_mon();
        exp_coins.delete();
        topup5 = topup - (topup % 5);
        if (item == 3'd0)          exp_res = 3'd6;
        else if (st == 2'b10)      exp_res = 3'd1;
        else if (st == 2'b11)      exp_res = 3'd2;
        else if (errw)             exp_res = 3'd2;
        else if (!ins)             exp_res = 3'd5;
        else begin
            add_coins(amount);
            if (to_after > 0 && to_after <= exp_coins.size()) begin
                exp_res = 3'd3;
                while (exp_coins.size() > to_after) void'(exp_coins.pop_back());
            end else if (!r0)       exp_res = 3'd0;
            else if (topup5 != 0) begin
                add_coins(topup5);
                exp_res = r1 ? 3'd4 : 3'd0;
            end else                exp_res = 3'd4;
        end

        chk({tag, "/ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_item = item;
        req_amount = AMT_W'(amount); req_topup = AMT_W'(topup);
        step();
        req_valid = 1'b0; req_item = 3'($urandom_range(7));
        req_amount = AMT_W'($urandom); req_topup = AMT_W'($urandom);
        chk({tag, "/accept"}, {29'd0, buttons}, {29'd0, item});
        cyc = 0;
        while (done_cnt == 0 && cyc < 300) begin step(); cyc++; end
        chk({tag, "/result"}, 32'(done_res), 32'(exp_res));
        chk({tag, "/idle_outs_on_done"}, 32'(done_bus), 32'd0);
        chk({tag, "/ncoins"}, 32'(obs_coins.size()), 32'(exp_coins.size()));
        for (int i = 0; i < exp_coins.size() && i < obs_coins.size(); i++)
            chk($sformatf("%s/coin%0d", tag, i), 32'(obs_coins[i]), 32'(exp_coins[i]));
        chk({tag, "/srst_cycles"}, 32'(srst_cyc),
            (exp_res == 3'd2 || exp_res == 3'd5) ? 32'd2 : 32'd0);
        chk({tag, "/select_seen"}, 32'(sel_seen),
            (exp_res == 3'd0 || exp_res == 3'd4) ? 32'd1 : 32'd0);
        step();
        chk({tag, "/done_once"}, 32'(done_cnt), 32'd1);
        chk({tag, "/back_idle"}, {30'd0, done, req_ready}, 32'b01);
    endtask

    initial begin
        int cyc;
        m_status = 2'b01; m_ins = 1'b1; m_err_wait = 1'b0; m_to_after = 0;
        m_r0 = 1'b0; m_r1 = 1'b0; wait_cnt = 0; sel_cnt = 0; timer_dropped = 1'b0;
        clear_mon();

        #12;
        chk("reset/outs", {25'd0, buttons, coin, select, srst, done}, 32'd0);
        chk("reset/ready_result", {28'd0, req_ready, result}, {28'd0, 1'b1, 3'd0});
        hrst_n = 1'b1;
        step(); step();

        do_txn("t1_basic40",   3'd3, 40, 0,  2'b01, 1, 0, 0, 0, 0);
        do_txn("t2_oos",       3'd5, 50, 0,  2'b10, 1, 0, 0, 0, 0);
        do_txn("t3_topup_ok",  3'd2, 10, 25, 2'b01, 1, 0, 0, 1, 0);
        do_txn("t3_topup_bad", 3'd2, 10, 25, 2'b01, 1, 0, 0, 1, 1);
        do_txn("t4_timeout",   3'd4, 75, 0,  2'b01, 1, 0, 1, 0, 0);
        do_txn("t5_err_wait",  3'd1, 30, 0,  2'b01, 0, 1, 0, 0, 0);
        do_txn("t5_wdog",      3'd6, 30, 0,  2'b01, 0, 0, 0, 0, 0);
        do_txn("err_press",    3'd7, 20, 0,  2'b11, 1, 0, 0, 0, 0);
        do_txn("round44",      3'd1, 44, 0,  2'b01, 1, 0, 0, 0, 0);
        do_txn("amount0",      3'd2, 0,  0,  2'b01, 1, 0, 0, 0, 0);
        do_txn("insuff_none",  3'd3, 15, 3,  2'b01, 1, 0, 0, 1, 0);

        // Reset in the middle of a payment
        m_status = 2'b01; m_ins = 1'b1; m_err_wait = 1'b0; m_to_after = 0;
        clear_mon();
        req_valid = 1'b1; req_item = 3'd3; req_amount = AMT_W'(200); req_topup = '0;
        step();
        req_valid = 1'b0;
        cyc = 0;
        while (coins_seen == 0 && cyc < 20) begin step(); cyc++; end
        chk("t6/in_pay", 32'(coins_seen > 0), 32'd1);
        #2 hrst_n = 1'b0;
        #1;
        chk("t6/async_outs", {25'd0, buttons, coin, select, srst, done}, 32'd0);
        chk("t6/async_ready", 32'(req_ready), 32'd1);
        step(); step();
        hrst_n = 1'b1;
        done_cnt = 0;
        repeat (4) step();
        chk("t6/no_done", 32'(done_cnt), 32'd0);
        do_txn("t6_badreq",    3'd0, 40, 0,  2'b01, 1, 0, 0, 0, 0);

        for (int k = 0; k < 12; k++) begin
            logic [2:0] it;
            int         am, tu;
            it = 3'($urandom_range(1, 7));
            am = int'($urandom_range(0, 255));
            tu = ($urandom_range(1) == 0) ? 0 : int'($urandom_range(0, 255));
            do_txn($sformatf("rnd%0d", k), it, am, tu,
                   ($urandom_range(7) == 0) ? 2'b10 : 2'b01, 1, 0, 0,
                   1'($urandom_range(1)), 1'($urandom_range(1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
